// File: rtl/fpu_sched.sv
// fpu_sched: round-robin arbiter sharing one pipelined FPU between two requesters, with per-requester response buffers
module fpu_sched #(
  parameter int LAT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid_i,
  output logic [1:0]  req_ready_o,
  input  logic [7:0]  req_mode_i,
  input  logic [31:0] req_a_i,
  input  logic [31:0] req_b_i,
  output logic [3:0]  fpu_mode_o,
  output logic [15:0] fpu_in1_o,
  output logic [15:0] fpu_in2_o,
  input  logic [15:0] fpu_out_i,
  input  logic        fpu_ovf_i,
  output logic [1:0]  rsp_valid_o,
  input  logic [1:0]  rsp_ready_i,
  output logic [31:0] rsp_data_o,
  output logic [1:0]  rsp_ovf_o,
  output logic [1:0]  rsp_err_o
);
  logic [1:0]  busy, elig, grant, rsp_hs;
  logic        last, hs, id, legal;
  logic [3:0]  sel_mode;
  logic [15:0] sel_a, sel_b;
  logic        tv [LAT+1];
  logic        tid [LAT+1];
  logic        terr [LAT+1];
  assign rsp_hs = rsp_valid_o & rsp_ready_i;
  assign elig = req_valid_i & ~busy & ~rsp_hs;
  assign grant = {elig[1] & (~elig[0] | ~last), elig[0] & (~elig[1] | last)};
  assign req_ready_o = rst ? 2'b00 : grant;
  assign hs = |req_ready_o;
  assign id = req_ready_o[1];
  assign sel_mode = id ? req_mode_i[7:4] : req_mode_i[3:0];
  assign sel_a = id ? req_a_i[31:16] : req_a_i[15:0];
  assign sel_b = id ? req_b_i[31:16] : req_b_i[15:0];
  assign legal = $onehot(sel_mode);
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 2'b00;
      last <= 1'b1;
      fpu_mode_o <= 4'b0000;
      fpu_in1_o <= 16'h0;
      fpu_in2_o <= 16'h0;
      for (int k = 0; k <= LAT; k++) begin
        tv[k] <= 1'b0;
        tid[k] <= 1'b0;
        terr[k] <= 1'b0;
      end
      rsp_valid_o <= 2'b00;
      rsp_data_o <= 32'h0;
      rsp_ovf_o <= 2'b00;
      rsp_err_o <= 2'b00;
    end else begin
      busy <= (busy | req_ready_o) & ~rsp_hs;
      if (hs) last <= id;
      fpu_mode_o <= (hs && legal) ? sel_mode : 4'b0000;
      if (hs) begin
        fpu_in1_o <= sel_a;
        fpu_in2_o <= sel_b;
      end
      tv[0] <= hs;
      tid[0] <= id;
      terr[0] <= ~legal;
      for (int k = 1; k <= LAT; k++) begin
        tv[k] <= tv[k-1];
        tid[k] <= tid[k-1];
        terr[k] <= terr[k-1];
      end
      for (int j = 0; j < 2; j++) begin
        if (rsp_hs[j]) begin
          rsp_valid_o[j] <= 1'b0;
          rsp_data_o[16*j +: 16] <= 16'h0;
          rsp_ovf_o[j] <= 1'b0;
          rsp_err_o[j] <= 1'b0;
        end
      end
      if (tv[LAT]) begin
        rsp_valid_o[tid[LAT]] <= 1'b1;
        rsp_data_o[16*tid[LAT] +: 16] <= terr[LAT] ? 16'h7FC0 : fpu_out_i;
        rsp_ovf_o[tid[LAT]] <= ~terr[LAT] & fpu_ovf_i;
        rsp_err_o[tid[LAT]] <= terr[LAT];
      end
    end
  end
endmodule

// File: doc/fpu_sched.md
FPU_SCHED -- requirements
Module: fpu_sched

Interface
REQ-001 Parameter: LAT, 0, FPU result latency in cycles after operands are presented (legal 0..3).
REQ-002 clk  input  1  clock, all state on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req_valid_i  input  2  per-requester request valid; bit i = requester i.
REQ-005 req_ready_o  output  2  per-requester request accept.
REQ-006 req_mode_i  input  8  one-hot op per requester, [4i+3:4i]: 0001 add, 0010 sub, 0100 mul, 1000 div.
REQ-007 req_a_i  input  32  bfloat16 operand A per requester, [16i+15:16i].
REQ-008 req_b_i  input  32  bfloat16 operand B per requester, [16i+15:16i].
REQ-009 fpu_mode_o  output  4  op to shared FPU; 0000 when no op issued.
REQ-010 fpu_in1_o  output  16  operand A to FPU.
REQ-011 fpu_in2_o  output  16  operand B to FPU.
REQ-012 fpu_out_i  input  16  FPU result.
REQ-013 fpu_ovf_i  input  1  FPU overflow flag, same timing as fpu_out_i.
REQ-014 rsp_valid_o  output  2  per-requester response valid.
REQ-015 rsp_ready_i  input  2  per-requester response accept.
REQ-016 rsp_data_o  output  32  per-requester result, [16i+15:16i].
REQ-017 rsp_ovf_o  output  2  per-requester overflow flag.
REQ-018 rsp_err_o  output  2  per-requester illegal-mode flag.

Function
REQ-019 busy[i] SHALL set on request handshake of i and clear on response handshake of i; at most one outstanding op per requester.
REQ-020 eligible[i] = req_valid_i[i] & ~busy[i]; eligibility of a requester whose response handshake occurs this cycle SHALL be 0 that cycle (accept earliest next cycle).
REQ-021 Round-robin: at most one grant per cycle; if both eligible, grant the requester not granted most recently; pointer updates only on a grant.
REQ-022 req_ready_o[i] SHALL be combinational = eligible[i] & grant[i]; never high for both bits.
REQ-023 On handshake in cycle t, fpu_mode_o/fpu_in1_o/fpu_in2_o SHALL be registered and present in cycle t+1; with no handshake, fpu_mode_o SHALL be 0000 next cycle and operands hold.
REQ-024 Illegal mode (not exactly one bit set) SHALL be accepted, SHALL NOT be issued (fpu_mode_o 0000), and SHALL travel the tag pipeline flagged err.
REQ-025 A tag pipeline of LAT+1 stages SHALL carry {valid, id, err} from handshake to capture; fpu_out_i/fpu_ovf_i SHALL be sampled at end of cycle t+1+LAT.
REQ-026 Capture SHALL load response buffer id: data=fpu_out_i, ovf=fpu_ovf_i, err=0; for err tags data=16'h7FC0, ovf=0, err=1.
REQ-027 rsp_valid_o[id] SHALL rise in cycle t+2+LAT and hold with data/ovf/err stable until rsp_ready_i[id] handshake; clears the following cycle.
REQ-028 Back-to-back issue (one per cycle, alternating requesters) SHALL be supported without bubbles; a stalled response of one requester SHALL NOT block the other.
REQ-029 rsp_* fields SHALL be zero when the corresponding rsp_valid_o bit is 0.

Reset
REQ-030 While rst=1 at a clock edge: busy, tag pipeline, response buffers cleared; rsp_valid_o=00, rsp_data_o=0, rsp_ovf_o=00, rsp_err_o=00, fpu_mode_o=0000, fpu_in1_o=fpu_in2_o=0; round-robin pointer prefers requester 0.
REQ-031 req_ready_o SHALL be 00 while rst=1; reset mid-operation SHALL discard in-flight ops with no response produced.

Verification
REQ-032 LAT=0, req0 add A=3F80 B=4000 in cycle t -> req_ready_o=01 in t; fpu_mode_o=0001, fpu_in1_o=3F80 in t+1; rsp_valid_o[0]=1, data 4040 in t+2.
REQ-033 Both valid from reset, add ops, rsp_ready_i=11 -> grants req0 in t, req1 in t+1, then alternate; fpu_mode_o never 0000 between them.
REQ-034 rsp_ready_i[0]=0 for 5 cycles after req0 result -> rsp_valid_o[0] and data held, req_ready_o[0]=0 throughout, req1 issues continue.
REQ-035 req1 mode 0011 -> fpu_mode_o=0000 in t+1; rsp1 data 7FC0, rsp_err_o[1]=1, rsp_ovf_o[1]=0 in t+2+LAT.
REQ-036 LAT=2, req0 mul 7F00*7F00, FPU model asserts overflow -> rsp_ovf_o[0]=1 in t+4 with fpu_out_i value.
REQ-037 rst asserted cycle after a handshake -> next cycle all outputs at reset values; no rsp_valid_o ever asserts for that op.
